// File: rtl/output_buffer_pkg.sv
// Shared types and helpers for the output buffer: FSM encoding, default beat
// geometry and the byte-count to beat-count ceil-divide.
package output_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF  = 512;
  localparam int DATA_WIDTH_BYTE = DATA_WIDTH_DEF / 8;

  // Computed in 33 bits so out_byte near 2^32 cannot wrap before the divide.
  function automatic logic [32:0] beats_ceil(input logic [31:0] bytes, input int bw_byte);
    logic [32:0] sum;
    sum = {1'b0, bytes} + 33'(bw_byte - 1);
    return sum / 33'(bw_byte);
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// Write-master channel of the output buffer: request/address/size, beat stream
// and completion. master = output buffer side, slave = AXI write master side.
interface output_buffer_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  wmst_req;
  logic [63:0]           addr_offset;
  logic [63:0]           xfer_size;
  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  o_tvalid;
  logic                  o_tready;
  logic                  wmst_done;

  modport master (
    output wmst_req, addr_offset, xfer_size, o_tdata, o_tvalid,
    input  o_tready, wmst_done
  );

  modport slave (
    input  wmst_req, addr_offset, xfer_size, o_tdata, o_tvalid,
    output o_tready, wmst_done
  );
endinterface

// File: rtl/output_buffer_out_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on rd_data while !empty,
// rd_en pops it. clear empties the FIFO without touching the storage.
module output_buffer_out_fifo #(
  parameter int W  = 512,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   data_cnt
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign empty   = (data_cnt == '0);
  assign full    = (data_cnt == (AW+1)'(DEPTH));
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_cnt <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   data_cnt <= data_cnt + (AW+1)'(1);
        2'b01:   data_cnt <= data_cnt - (AW+1)'(1);
        default: data_cnt <= data_cnt;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/output_buffer.sv
// Output buffer: queues conv-engine result beats and streams them to the write
// master. Optional stall counter under OUTPUT_BUFFER_STALL_CNT_EN.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int FIFO_ADDR_WIDTH = 7,
  parameter int BEAT_CNT_WIDTH  = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_start,
  input  logic [63:0]           addr_base,
  input  logic [31:0]           out_byte,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  full,
  output_buffer_if.master       wm,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           stall_cycles
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** FIFO_ADDR_WIDTH;
  localparam int CNT_W      = FIFO_ADDR_WIDTH + 1;

  state_t                    state;
  logic [BEAT_CNT_WIDTH-1:0] beats_left, total_beats, push_cnt, req_beats;
  logic                      done_seen;
  logic                      fifo_empty, fifo_full;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [DATA_WIDTH-1:0]     fifo_head;
  logic                      start_ok, push_ok, push_over, pop, last_beat;

  assign start_ok  = op_start & (state == ST_IDLE);
  assign req_beats = BEAT_CNT_WIDTH'(beats_ceil(out_byte, BEAT_BYTES));
  assign push_ok   = push_req & ~fifo_full & busy & (push_cnt <  total_beats);
  assign push_over = push_req & ~fifo_full & busy & (push_cnt >= total_beats);

  assign wm.o_tvalid = (state == ST_STREAM) & ~fifo_empty & (beats_left != '0);
  assign wm.o_tdata  = wm.o_tvalid ? fifo_head : '0;
  assign pop         = wm.o_tvalid & wm.o_tready;
  assign last_beat   = (beats_left == '0) | (pop & (beats_left == BEAT_CNT_WIDTH'(1)));
  assign full        = fifo_full;

  output_buffer_out_fifo #(
    .W  (DATA_WIDTH),
    .AW (FIFO_ADDR_WIDTH)
  ) out_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .wr_en    (push_ok),
    .wr_data  (i_data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .data_cnt (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      wm.wmst_req    <= 1'b0;
      wm.addr_offset <= '0;
      wm.xfer_size   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      done_seen      <= 1'b0;
      beats_left     <= '0;
      total_beats    <= '0;
      push_cnt       <= '0;
    end else begin
      wm.wmst_req <= 1'b0;
      done        <= 1'b0;
      if (push_ok)   push_cnt <= push_cnt + BEAT_CNT_WIDTH'(1);
      if (push_over) overflow <= 1'b1;
      // An early completion from the write master is remembered, never dropped.
      if ((state == ST_REQ || state == ST_STREAM) && wm.wmst_done) done_seen <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (op_start) begin
            wm.addr_offset <= addr_base;
            wm.xfer_size   <= {32'd0, out_byte};
            beats_left     <= req_beats;
            total_beats    <= req_beats;
            push_cnt       <= '0;
            overflow       <= 1'b0;
            done_seen      <= 1'b0;
            busy           <= 1'b1;
            wm.wmst_req    <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: state <= ST_STREAM;
        ST_STREAM: begin
          if (pop) beats_left <= beats_left - BEAT_CNT_WIDTH'(1);
          if (last_beat) begin
            if (done_seen || wm.wmst_done) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (wm.wmst_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      stall_cycles <= '0;
    else if (wm.o_tvalid && !wm.o_tready && !(&stall_cycles))
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

  a_fifo_cnt_range: assert property (@(posedge clk) disable iff (rst) fifo_cnt <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: handshake timing, backpressure, FIFO full,
// overflow, early wmst_done, zero-length and mid-op reset.
module tb_output_buffer;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst, op_start, push_req;
  logic [63:0]   addr_base;
  logic [31:0]   out_byte;
  logic [DW-1:0] i_data;
  logic          full, busy, done, overflow;
  logic [31:0]   stall_cycles;

  output_buffer_if #(.DATA_WIDTH(DW)) wm();

  output_buffer #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(7), .BEAT_CNT_WIDTH(26)) dut (
    .clk(clk), .rst(rst), .op_start(op_start), .addr_base(addr_base), .out_byte(out_byte),
    .push_req(push_req), .i_data(i_data), .full(full), .wm(wm), .busy(busy), .done(done),
    .overflow(overflow), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int            checks = 0, errors = 0;
  logic [DW-1:0] rx[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hC0DE_0000;
    return {(DW/32){w}};
  endfunction

  // Stream monitor: collects accepted beats and checks the hold rule on stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", DW'(wm.o_tvalid), DW'(1));
        chk("hold_data", wm.o_tdata, prev_data);
      end
      if (wm.o_tvalid && wm.o_tready) rx.push_back(wm.o_tdata);
      prev_stall <= wm.o_tvalid && !wm.o_tready;
      prev_data  <= wm.o_tdata;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset();
    chk("rst_full", DW'(full), '0);
    chk("rst_wmst_req", DW'(wm.wmst_req), '0);
    chk("rst_addr_offset", DW'(wm.addr_offset), '0);
    chk("rst_xfer_size", DW'(wm.xfer_size), '0);
    chk("rst_tvalid", DW'(wm.o_tvalid), '0);
    chk("rst_tdata", wm.o_tdata, '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_overflow", DW'(overflow), '0);
    chk("rst_stall", DW'(stall_cycles), '0);
  endtask

  task automatic start_op(input logic [63:0] addr, input logic [31:0] bytes);
    addr_base = addr; out_byte = bytes; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    chk("wmst_req_rise", DW'(wm.wmst_req), DW'(1));
    chk("busy_rise", DW'(busy), DW'(1));
    chk("addr_offset", DW'(wm.addr_offset), DW'(addr));
    chk("xfer_size", DW'(wm.xfer_size), DW'({32'd0, bytes}));
    tick();
    chk("wmst_req_fall", DW'(wm.wmst_req), '0);
    rx.delete();
  endtask

  task automatic push(input int i);
    int n = 0;
    while (full && n < 1000) begin tick(); n++; end
    if (n >= 1000) chk("full_timeout", DW'(full), '0);
    push_req = 1'b1; i_data = beat(i);
    tick();
    push_req = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx.size() < n && k < 2000) begin tick(); k++; end
    chk("rx_count", DW'(rx.size()), DW'(n));
  endtask

  task automatic check_rx(input int base, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("beat%0d", i), (i < rx.size()) ? rx[i] : '0, beat(base + i));
  endtask

  task automatic finish_op();
    wm.wmst_done = 1'b1;
    tick();
    wm.wmst_done = 1'b0;
    chk("done_pulse", DW'(done), DW'(1));
    chk("busy_clear", DW'(busy), '0);
    tick();
    chk("done_fall", DW'(done), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_start = 1'b0; push_req = 1'b0; addr_base = '0; out_byte = '0; i_data = '0;
    wm.o_tready = 1'b0; wm.wmst_done = 1'b0;
    tick(); tick();
    check_reset();
    rst = 1'b0;
    tick();

    // 4 beats, no backpressure
    wm.o_tready = 1'b1;
    start_op(64'h1000, 32'd256);
    for (int i = 0; i < 4; i++) push(i);
    wait_rx(4);
    check_rx(0, 4);
    chk("t1_wait_busy", DW'(busy), DW'(1));
    chk("t1_wait_nodone", DW'(done), '0);
    chk("t1_wait_tvalid", DW'(wm.o_tvalid), '0);
    finish_op();

    // 8 beats, 7 stalls while queuing then 7 more from ready toggling
    wm.o_tready = 1'b0;
    start_op(64'h8000, 32'd512);
    for (int i = 0; i < 8; i++) push(10 + i);
    for (int i = 0; i < 16; i++) begin
      wm.o_tready = (i % 2 == 0);
      tick();
    end
    wm.o_tready = 1'b1;
    chk("t2_rx_count", DW'(rx.size()), DW'(8));
    check_rx(10, 8);
`ifdef OUTPUT_BUFFER_STALL_CNT_EN
    chk("t2_stall_cycles", DW'(stall_cycles), DW'(14));
`else
    chk("t2_stall_cycles", DW'(stall_cycles), '0);
`endif
    finish_op();

    // 200 beats against a 128-deep FIFO
    wm.o_tready = 1'b0;
    start_op(64'h10000, 32'd12800);
    chk("t3_stall_cleared", DW'(stall_cycles), '0);
    for (int i = 0; i < 128; i++) push(100 + i);
    chk("t3_full_set", DW'(full), DW'(1));
    push_req = 1'b1; i_data = beat(999); wm.o_tready = 1'b1;
    tick();
    push_req = 1'b0;
    chk("t3_full_pop", DW'(full), '0);
    for (int i = 128; i < 200; i++) push(100 + i);
    wait_rx(200);
    check_rx(100, 200);
    chk("t3_full_drop", DW'(full), '0);
    chk("t3_no_overflow", DW'(overflow), '0);
    finish_op();

    // 100 bytes -> 2 beats, third push overflows
    start_op(64'h2_0000, 32'd100);
    push(300); push(301);
    chk("t4_overflow_pre", DW'(overflow), '0);
    push(302);
    chk("t4_overflow", DW'(overflow), DW'(1));
    wait_rx(2);
    check_rx(300, 2);
    finish_op();
    chk("t4_overflow_sticky", DW'(overflow), DW'(1));

    // zero-length operation
    start_op(64'h3000, 32'd0);
    chk("t0_overflow_clr", DW'(overflow), '0);
    tick(); tick();
    chk("t0_tvalid", DW'(wm.o_tvalid), '0);
    chk("t0_busy", DW'(busy), DW'(1));
    finish_op();
    chk("t0_rx_none", DW'(rx.size()), '0);

    // wmst_done seen during STREAM: done on the edge of the last transfer
    wm.o_tready = 1'b0;
    start_op(64'h5000, 32'd128);
    push(400); push(401);
    wm.wmst_done = 1'b1;
    tick();
    wm.wmst_done = 1'b0;
    chk("t5_early_nodone", DW'(done), '0);
    chk("t5_early_busy", DW'(busy), DW'(1));
    wm.o_tready = 1'b1;
    tick();
    chk("t5_first_nodone", DW'(done), '0);
    tick();
    chk("t5_done", DW'(done), DW'(1));
    chk("t5_busy_clear", DW'(busy), '0);
    tick();
    chk("t5_done_fall", DW'(done), '0);
    check_rx(400, 2);

    // reset mid-STREAM with 5 beats queued, then a clean run
    wm.o_tready = 1'b0;
    start_op(64'h4000, 32'd640);
    for (int i = 0; i < 5; i++) push(500 + i);
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    tick();
    chk("t6_no_done", DW'(done), '0);
    wm.o_tready = 1'b1;
    start_op(64'h2000, 32'd128);
    push(50); push(51);
    wait_rx(2);
    check_rx(50, 2);
    finish_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
